// File: rtl/mips_fetch_stage.sv
// Instruction fetch: PC, byte-addressed big-endian instruction memory, and the fetch buffer to decode.
// One instruction per cycle in RUN; redirect beats stall beats fetch, and fetching stops after HALT.
module mips_fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 4096,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'h11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_en,
    input  logic [$clog2(MEM_DEPTH/4)-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]         load_data,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic                           fb_valid,
    output logic [ADDR_WIDTH-1:0]          fb_pc,
    output logic [INSTR_WIDTH-1:0]         fb_instr,
    output logic [31:0]                    fetch_count,
    output logic [1:0]                     state
);
    localparam int WORDS = MEM_DEPTH / 4;
    localparam int LW    = $clog2(WORDS);
    localparam int BW    = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   fb_pc_q;
    logic                    fb_valid_q;
    logic [INSTR_WIDTH-1:0]  fb_instr_q;
    logic [31:0]             count_q;

    // Stored one word per entry with byte 4*idx in the top bits, so a read is already big-endian.
    logic [INSTR_WIDTH-1:0]  mem_q [WORDS];

    logic [LW-1:0]           rd_idx;
    logic [INSTR_WIDTH-1:0]  rd_word;
    logic                    rd_is_halt;
    logic [ADDR_WIDTH-1:0]   redir_pc_d;
    logic [ADDR_WIDTH-1:0]   pc_inc_d;

    assign rd_idx     = pc_q[BW-1:2];
    assign rd_word    = mem_q[rd_idx];
    assign rd_is_halt = (rd_word[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);
    assign redir_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
    assign pc_inc_d   = pc_q + ADDR_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (load_en && state_q == S_IDLE) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            fb_valid_q <= 1'b0;
            fb_pc_q    <= '0;
            fb_instr_q <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pc_q    <= RESET_PC;
                    end
                end
                S_RUN: begin
                    if (redirect) begin
                        pc_q       <= redir_pc_d;
                        fb_valid_q <= 1'b0;
                        fb_instr_q <= '0;
                    end else if (!stall) begin
                        fb_pc_q    <= pc_q;
                        fb_instr_q <= rd_word;
                        fb_valid_q <= 1'b1;
                        pc_q       <= pc_inc_d;
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_q <= count_q + 32'd1;
                        end
                        if (rd_is_halt) begin
                            state_q <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    // A redirect means the HALT sat on a squashed path, so fetching resumes.
                    if (redirect) begin
                        pc_q       <= redir_pc_d;
                        fb_valid_q <= 1'b0;
                        fb_instr_q <= '0;
                        state_q    <= S_RUN;
                    end else if (!stall) begin
                        fb_valid_q <= 1'b0;
                        fb_instr_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_valid    = fb_valid_q;
    assign fb_pc       = fb_pc_q;
    assign fb_instr    = fb_instr_q;
    assign fetch_count = count_q;
    assign state       = state_q;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed plus randomized bench for mips_fetch_stage against a behavioural fetch model.
module tb_mips_fetch_stage;
    localparam int MEM_DEPTH = 4096;
    localparam int WORDS     = MEM_DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fb_valid;
    logic [31:0] fb_pc;
    logic [31:0] fb_instr;
    logic [31:0] fetch_count;
    logic [1:0]  state;

    mips_fetch_stage dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_instr(fb_instr),
        .fetch_count(fetch_count), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: word memory, PC and fetch buffer as plain variables.
    logic [31:0] mm [WORDS];
    int          m_state;
    logic [31:0] m_pc, m_fbpc, m_instr, m_cnt;
    logic        m_vld;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_vld = 1'b0; m_fbpc = 0; m_instr = 0; m_cnt = 0;
    endtask

    task automatic model_redirect();
        m_pc    = redirect_pc - (redirect_pc % 4);
        m_vld   = 1'b0;
        m_instr = 0;
    endtask

    task automatic model_fetch();
        logic [31:0] w;
        w       = mm[int'((m_pc % 32'(MEM_DEPTH)) / 4)];
        m_fbpc  = m_pc;
        m_instr = w;
        m_vld   = 1'b1;
        m_pc    = m_pc + 32'd4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (w[31:26] == 6'h11) m_state = 2;
    endtask

    task automatic model_edge();
        case (m_state)
            0: begin
                if (load_en) mm[load_addr] = load_data;
                if (start) begin m_state = 1; m_pc = 0; end
            end
            1: if (redirect) model_redirect(); else if (!stall) model_fetch();
            default: begin
                if (redirect) begin model_redirect(); m_state = 1; end
                else if (!stall) begin m_vld = 1'b0; m_instr = 0; end
            end
        endcase
    endtask

    task automatic check_all();
        chk("fb_valid", {31'b0, fb_valid}, {31'b0, m_vld});
        chk("fb_pc", fb_pc, m_fbpc);
        chk("fb_instr", fb_instr, m_instr);
        chk("fetch_count", fetch_count, m_cnt);
        chk("state", {30'b0, state}, 32'(m_state));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] held_cnt;
        model_reset();
        #2;
        check_all();
        #10 rst = 1'b0;

        // Fill all of memory so no read ever sees uninitialised contents.
        load_en = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h11) w[31:26] = 6'h12;
            if (i >= 16 && i < 1000 && $urandom_range(0, 31) == 0) w[31:26] = 6'h11;
            load_addr = 10'(i);
            load_data = w;
            step();
        end
        load_addr = 10'd0; load_data = 32'h2001_0005; step();
        load_addr = 10'd1; load_data = 32'h2002_0003; step();
        load_addr = 10'd2; load_data = 32'h4400_0000; step();
        load_en = 1'b0;

        start = 1'b1; step(); start = 1'b0;
        chk("start_state", {30'b0, state}, 32'd1);
        step(); chk("pc0", fb_pc, 32'h0); chk("instr0", fb_instr, 32'h2001_0005);
        step(); chk("pc4", fb_pc, 32'h4); chk("instr4", fb_instr, 32'h2002_0003);
        step(); chk("pc8", fb_pc, 32'h8); chk("instr8", fb_instr, 32'h4400_0000);
        step();
        chk("halt_state", {30'b0, state}, 32'd2);
        chk("halt_valid", {31'b0, fb_valid}, 32'd0);
        chk("halt_count", fetch_count, 32'd3);

        redirect = 1'b1; redirect_pc = 32'h10; step(); redirect = 1'b0;
        chk("unhalt_state", {30'b0, state}, 32'd1);
        step(); chk("unhalt_pc", fb_pc, 32'h10); chk("unhalt_valid", {31'b0, fb_valid}, 32'd1);

        redirect = 1'b1; redirect_pc = 32'h0; step(); redirect = 1'b0;
        step(); step();
        held_cnt = fetch_count;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", fb_pc, 32'h4);
            chk("stall_instr", fb_instr, 32'h2002_0003);
            chk("stall_cnt", fetch_count, held_cnt);
        end
        stall = 1'b0; step(); chk("post_stall_pc", fb_pc, 32'h8);

        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_001E; step();
        redirect = 1'b0; stall = 1'b0;
        chk("rs_valid", {31'b0, fb_valid}, 32'd0); chk("rs_instr", fb_instr, 32'd0);
        step(); chk("rs_pc", fb_pc, 32'h1C);

        redirect = 1'b1; redirect_pc = 32'h0000_0FFC; step(); redirect = 1'b0;
        step(); chk("wrap_pc0", fb_pc, 32'hFFC);
        step(); chk("wrap_pc1", fb_pc, 32'h1000); chk("wrap_instr", fb_instr, 32'h2001_0005);

        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            load_en     = ($urandom_range(0, 7) == 0);
            load_addr   = 10'($urandom);
            load_data   = $urandom;
            start       = ($urandom_range(0, 15) == 0);
            step();
        end
        stall = 1'b0; start = 1'b0;

        // A write attempted while running must be dropped; it is read back after reset.
        redirect = 1'b1; redirect_pc = 32'h0;
        load_en = 1'b1; load_addr = 10'd5; load_data = 32'h4400_0000;
        step();
        redirect = 1'b0; load_en = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_valid", {31'b0, fb_valid}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_state", {30'b0, state}, 32'd0);
        rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h14; step(); redirect = 1'b0;
        step();
        chk("noload_pc", fb_pc, 32'h14);
        chk("noload_instr", fb_instr, mm[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the MIPS-lite 5-stage pipeline. It holds the program counter and a byte-addressed 4096-byte instruction memory, loaded word-by-word before the run. Each run cycle it delivers one big-endian 32-bit instruction plus its PC into the fetch buffer consumed by decode. It honours hazard stalls from decode and taken-branch redirects from execute, and stops fetching after the HALT opcode.

## Interface

- ADDR_WIDTH, 32, PC and redirect address width
- MEM_DEPTH, 4096, instruction memory size in bytes (power of two, multiple of 4)
- INSTR_WIDTH, 32, instruction width; 4 bytes per instruction
- RESET_PC, 0, PC loaded on reset and on start
- HALT_OPCODE, 6'h11, opcode (instr[31:26]) that ends fetching

Ports:

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  write one instruction word into memory (IDLE only)
- load_addr  in  $clog2(MEM_DEPTH/4)  word index
- load_data  in  32  word; bits [31:24] go to byte 4*idx, [7:0] to byte 4*idx+3
- start  in  1  one-cycle pulse, IDLE -> RUN
- stall  in  1  hazard stall from decode; freeze PC and buffer
- redirect  in  1  taken branch from execute
- redirect_pc  in  ADDR_WIDTH  branch target
- fb_valid  out  1  fetch buffer holds a real instruction
- fb_pc  out  ADDR_WIDTH  PC of fb_instr
- fb_instr  out  32  fetched instruction (0 = bubble/NOP when invalid)
- fetch_count  out  32  instructions delivered with fb_valid=1
- state  out  2  0 IDLE, 1 RUN, 2 HALTED

## Operation

- Reset: state=IDLE, pc=RESET_PC, fb_valid=0, fb_pc=0, fb_instr=0, fetch_count=0. Memory contents are not cleared.
- Memory index is pc[$clog2(MEM_DEPTH)-1:0] with bits [1:0] forced to 0. The PC wraps modulo MEM_DEPTH for addressing only. The PC register itself increments at full ADDR_WIDTH and wraps at 2^32.
- Memory read is combinational from the array. The result is registered into fb_*.
- IDLE:
  - load_en writes the word on the clock edge.
  - start sets pc=RESET_PC and moves to RUN.
  - If load_en and start are asserted together, the write happens and the state goes to RUN.
  - stall and redirect are ignored.
- RUN, priority redirect > stall > fetch:
  - redirect: pc <= redirect_pc & ~3, fb_valid <= 0, fb_instr <= 0, fb_pc unchanged. fetch_count is unchanged.
  - stall (no redirect): pc, fb_*, and fetch_count hold.
  - fetch: fb_pc <= pc, fb_instr <= mem word, fb_valid <= 1, pc <= pc+4, fetch_count++ (saturates at 2^32-1). If the fetched word's opcode is HALT_OPCODE, state <= HALTED in the same edge. The HALT word is still delivered.
- HALTED:
  - No stall, no redirect: fb_valid <= 0, fb_instr <= 0, and pc holds.
  - stall: fb_* hold, so the HALT word stays presented to decode.
  - redirect: the HALT was on a squashed path. Apply the RUN redirect action and go to RUN.
- load_en outside IDLE is ignored; memory is unchanged.
- start outside IDLE is ignored.
- Only rst returns the block to IDLE.

## Timing

- Start latency: start sampled high at edge N puts the block in RUN after N. The first fb_valid=1 appears after edge N+1 with fb_pc=RESET_PC.
- Throughput: one instruction per cycle while stall=0 and redirect=0.
- Redirect penalty: redirect at edge M produces a bubble after M. The target instruction is presented after M+1.
- Stall is level-sensitive. Outputs are bit-identical for every stalled cycle, and fetch resumes from the held pc on the first edge with stall=0.
- Redirect and stall in the same cycle: redirect wins, and the bubble is emitted even while stall=1.
- rst asserted mid-run clears all outputs immediately, without waiting for a clock edge.

## Test plan

- Load words 0x20010005 (idx0), 0x20020003 (idx1), 0x44000000 (idx2, HALT); pulse start -> fb_pc 0,4,8 on consecutive cycles with those words, then state=2, fb_valid=0, fetch_count=3.
- Run with stall held 3 cycles while fb_pc=4 -> fb_pc=4 and fb_instr constant for 3 cycles, fetch_count frozen, next fetch fb_pc=8.
- redirect=1, redirect_pc=0x0000001E in the same cycle as stall=1 -> fb_valid=0, fb_instr=0; next cycle fb_pc=0x1C.
- HALT fetched, then redirect to 0x10 one cycle later -> state returns to 1, fb_pc=0x10 valid on the following cycle.
- Redirect to 0x00000FFC followed by 2 fetches -> fb_pc=0xFFC then fb_pc=0x1000, which reads the byte-0 word (address wrap).
- Assert rst asynchronously mid-run between edges -> fb_valid=0, fetch_count=0, state=0 immediately. load_en issued in RUN beforehand did not alter memory.
